ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It takes operands and the M-extension op from ID/EX, requests a pipeline stall while it iterates, and returns a 32-bit result with destination-register info for EX/MEM. A taken jump flushes it.

---
 rtl/ex_muldiv_pkg.sv | 21 ++
 rtl/ex_muldiv.sv | 163 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX-stage iterative RV32M multiply/divide unit:
// word width, M-extension funct3 encodings and FSM state encoding.
package ex_muldiv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply and restoring
// divide on operand magnitudes, sharing one 34-bit adder, with sign fix-up at the end.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      mdop_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      rd_i,
  input  logic            rd_enable_i,
  input  logic            jump_i,
  output logic            stall_req_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            rd_enable_o
);
  import ex_muldiv_pkg::*;

  logic [1:0]      state;
  logic [4:0]      cnt;
  logic [2:0]      op;
  logic [XLEN-1:0] mcand;      // multiplicand magnitude, or divisor magnitude
  logic [63:0]     acc;        // {high product / partial remainder, multiplier / quotient}
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;
  logic            rd_en_q;

  // Operand decode for the accept cycle
  logic            accept;
  logic            is_div;
  logic            sign1;
  logic            sign2;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    accept   = (state == ST_IDLE) && start_i && !jump_i;
    is_div   = mdop_i[2];
    sign1    = (mdop_i != MD_MULHU) && (mdop_i != MD_DIVU) && (mdop_i != MD_REMU);
    sign2    = sign1 && (mdop_i != MD_MULHSU);
    a_neg    = sign1 && reg1_i[XLEN-1];
    b_neg    = sign2 && reg2_i[XLEN-1];
    mag1     = a_neg ? -reg1_i : reg1_i;
    mag2     = b_neg ? -reg2_i : reg2_i;
    div_zero = is_div && (reg2_i == ZERO_WORD);
    div_ovf  = is_div && !mdop_i[0] && (reg1_i == {1'b1, {(XLEN-1){1'b0}}})
               && (reg2_i == {XLEN{1'b1}});
    if (div_zero)
      fast_result = mdop_i[1] ? reg1_i : {XLEN{1'b1}};
    else
      fast_result = mdop_i[1] ? ZERO_WORD : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Shared adder: accumulate for multiply, trial subtract for divide
  logic [33:0] add_a;
  logic [33:0] add_b;
  logic        add_cin;
  logic [33:0] add_sum;
  logic [63:0] acc_nxt;

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    if (op[2]) begin
      add_a   = {1'b0, acc[63:31]};
      add_b   = ~{2'b00, mcand};
      add_cin = 1'b1;
    end else begin
      add_a   = {2'b00, acc[63:32]};
      add_b   = {2'b00, mcand};
      add_cin = 1'b0;
    end
    add_sum = add_a + add_b + {33'd0, add_cin};
    if (op[2])
      acc_nxt = add_sum[33] ? {acc[62:0], 1'b0} : {add_sum[31:0], acc[30:0], 1'b1};
    else
      acc_nxt = acc[0] ? {add_sum[32:0], acc[31:1]} : {1'b0, acc[63:1]};
  end

  logic [63:0]     prod;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] final_result;

  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = neg_q ? -acc_nxt[31:0] : acc_nxt[31:0];
    rem  = neg_r ? -acc_nxt[63:32] : acc_nxt[63:32];
    case (op)
      MD_MUL:           final_result = prod[31:0];
      MD_DIV, MD_DIVU:  final_result = quo;
      MD_REM, MD_REMU:  final_result = rem;
      default:          final_result = prod[63:32];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op       <= MD_MUL;
      mcand    <= ZERO_WORD;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= ZERO_WORD;
      rd_q     <= '0;
      rd_en_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op      <= mdop_i;
            rd_q    <= rd_i;
            rd_en_q <= rd_enable_i;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            cnt     <= '0;
            mcand   <= is_div ? mag2 : mag1;
            acc     <= {ZERO_WORD, is_div ? mag1 : mag2};
            if (div_zero || div_ovf) begin
              result_q <= fast_result;
              state    <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (jump_i) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result_q <= final_result;
              state    <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall_req_o = accept || (state == ST_CALC);
  assign done_o      = (state == ST_DONE) && !jump_i;
  assign result_o    = result_q;
  assign rd_o        = rd_q;
  assign rd_enable_o = rd_en_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed vector table, random ops against a behavioural
// model, and hand sequences for flush, start-with-jump and reset mid-calculation.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  mdop_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  rd_i;
  logic        rd_enable_i;
  logic        jump_i;
  logic        stall_req_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        rd_enable_o;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mdop_i(mdop_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .rd_i(rd_i), .rd_enable_i(rd_enable_i),
    .jump_i(jump_i), .stall_req_o(stall_req_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o), .rd_enable_o(rd_enable_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rd_en;
    int          lat;
  } exp_t;

  exp_t scb[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] x, y, p;
    int sa, sb;
    sa = a;
    sb = b;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    case (op)
      MD_MUL:    begin p = x * y; return p[31:0]; end
      MD_MULH:   begin p = x * y; return p[63:32]; end
      MD_MULHSU: begin p = x * $signed({32'd0, b}); return p[63:32]; end
      MD_MULHU:  begin p = $signed({32'd0, a}) * $signed({32'd0, b}); return p[63:32]; end
      MD_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                 else return 32'(sa / sb);
      MD_REM:    if (b == 0) return a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                 else return 32'(sa % sb);
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drive one op, wait (bounded) for done_o, compare against the scoreboard head.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat,
                        input logic [4:0] rd, input logic rd_en);
    int   cyc;
    int   stalls;
    logic seen;
    exp_t e;
    @(posedge clk); #1;
    start_i = 1'b1; mdop_i = op; reg1_i = a; reg2_i = b; rd_i = rd; rd_enable_i = rd_en;
    scb.push_back('{res, rd, rd_en, lat});
    cyc = 0; stalls = 0; seen = 1'b0;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (stall_req_o) stalls++;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc++;
      end
    end
    start_i = 1'b0;
    e = scb.pop_front();
    check({name, "_done"}, 64'(seen), 64'd1);
    if (seen) begin
      check({name, "_result"}, 64'(result_o), 64'(e.res));
      check({name, "_rd"}, 64'({rd_enable_o, rd_o}), 64'({e.rd_en, e.rd}));
      check({name, "_latency"}, 64'(cyc), 64'(e.lat));
      check({name, "_stall_cycles"}, 64'(stalls), 64'(e.lat));
      check({name, "_stall_in_done"}, 64'(stall_req_o), 64'd0);
    end
  endtask

  initial begin
    int   seen_done;
    int   seen_stall;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b0; start_i = 1'b0; mdop_i = '0; reg1_i = '0; reg2_i = '0;
    rd_i = '0; rd_enable_i = 1'b0; jump_i = 1'b0;
    #2;
    check("reset_outputs", {29'd0, stall_req_o, done_o, rd_enable_o, rd_o, result_o},
          64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    vecs.push_back('{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{MD_MULH,   32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 33});
    vecs.push_back('{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{MD_DIVU,   32'd100,        32'd7,         32'd14,        33});
    vecs.push_back('{MD_REMU,   32'd100,        32'd7,         32'd2,         33});
    vecs.push_back('{MD_DIV,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         33});
    vecs.push_back('{MD_REM,    32'h8000_0000,  32'd3,         32'hFFFF_FFFE, 33});
    vecs.push_back('{MD_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33});
    vecs.push_back('{MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{MD_REM,    32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{MD_DIV,    32'd7,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{MD_REMU,   32'd7,          32'd0,         32'd7,         1});
    vecs.push_back('{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].lat, 5'(i + 1), i[0]);

    // done_o must be a single-cycle pulse
    @(negedge clk);
    check("done_single_pulse", 64'(done_o), 64'd0);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      rb  = (i % 6 == 0) ? 32'd0 : ((i % 4 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb),
             model_lat(rop, ra, rb), 5'(31 - i), ~i[0]);
    end

    // Flush in CALC cycle 10: no done, stall drops, next op is unaffected
    @(posedge clk); #1;
    start_i = 1'b1; mdop_i = MD_MUL; reg1_i = 32'd3; reg2_i = 32'd5;
    rd_i = 5'd9; rd_enable_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1; jump_i = 1'b1;
    @(negedge clk);
    check("jump_done_suppressed", 64'(done_o), 64'd0);
    @(posedge clk); #1; jump_i = 1'b0;
    @(negedge clk);
    check("jump_stall_low", 64'(stall_req_o), 64'd0);
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) seen_done++;
    end
    check("jump_no_done", 64'(seen_done), 64'd0);
    run_op("after_jump", MD_DIVU, 32'd100, 32'd7, 32'd14, 33, 5'd12, 1'b1);

    // start together with jump is not accepted
    @(posedge clk); #1;
    start_i = 1'b1; jump_i = 1'b1; mdop_i = MD_DIV; reg1_i = 32'd9; reg2_i = 32'd0;
    @(negedge clk);
    check("start_jump_no_stall", 64'(stall_req_o), 64'd0);
    @(posedge clk); #1; start_i = 1'b0; jump_i = 1'b0;
    seen_done = 0; seen_stall = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_o) seen_done++;
      if (stall_req_o) seen_stall++;
    end
    check("start_jump_ignored", 64'(seen_done + seen_stall), 64'd0);

    // Reset in CALC cycle 20 clears everything asynchronously
    @(posedge clk); #1;
    start_i = 1'b1; mdop_i = MD_MULHU; reg1_i = 32'hDEAD_BEEF; reg2_i = 32'h1234_5678;
    rd_i = 5'd17; rd_enable_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    check("pre_reset_stall", 64'(stall_req_o), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_reset_outputs", {29'd0, stall_req_o, done_o, rd_enable_o, rd_o, result_o},
          64'd0);
    @(negedge clk); rst = 1'b1;
    run_op("after_reset", MD_DIV, 32'd9, 32'd3, 32'd3, 33, 5'd4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
